// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams UART RX bytes into the byte-wide instruction
// memory write port, MSB first, and stops on a HALT word or a full memory.
// A one-byte pending buffer absorbs a strobe that lands while the FSM is
// busy writing or checking, so back-to-back bytes across word boundaries
// are not lost.
module inst_mem_loader #(
  parameter int          MEM_SIZE  = 8,
  parameter int          ADDR_SIZE = 8,
  parameter int          MEM_LARGE = 256,
  parameter int          INST_SIZE = 32,
  parameter logic [31:0] HALT_INST = 32'hFFFFFFFF
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic [MEM_SIZE-1:0]  i_rx_data,
  input  logic                 i_rx_done,
  output logic                 o_mem_enable,
  output logic                 o_mem_write_enable,
  output logic [MEM_SIZE-1:0]  o_mem_write_data,
  output logic [ADDR_SIZE-1:0] o_mem_write_addr,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [ADDR_SIZE-1:0] o_inst_count
);

  // Address counter carries one extra bit so the "memory full" value
  // MEM_LARGE is representable without wrapping back to 0.
  localparam logic [ADDR_SIZE:0]   MEM_END  = (ADDR_SIZE+1)'(MEM_LARGE);
  localparam logic [INST_SIZE-1:0] HALT_W   = INST_SIZE'(HALT_INST);
  localparam logic [ADDR_SIZE:0]   ADDR_ONE = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] CNT_ONE  = ADDR_SIZE'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BYTE = 3'd1,
    S_WRITE     = 3'd2,
    S_CHECK     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                 state_q,      state_d;
  logic [ADDR_SIZE:0]     addr_q,       addr_d;
  logic [1:0]             byte_idx_q,   byte_idx_d;
  logic [INST_SIZE-1:0]   word_q,       word_d;
  logic [MEM_SIZE-1:0]    pend_data_q,  pend_data_d;
  logic                   pend_vld_q,   pend_vld_d;
  logic                   wr_en_q,      wr_en_d;
  logic [MEM_SIZE-1:0]    wr_data_q,    wr_data_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q,    wr_addr_d;
  logic                   busy_q,       busy_d;
  logic                   done_q,       done_d;
  logic                   error_q,      error_d;
  logic [ADDR_SIZE-1:0]   inst_count_q, inst_count_d;

  // Next-state, datapath and pending-buffer logic for the load FSM.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    pend_data_d  = pend_data_q;
    pend_vld_d   = pend_vld_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    inst_count_d = inst_count_q;

    unique case (state_q)
      S_IDLE: begin
        // Strobes here are ignored; only i_start matters.
        if (i_start) begin
          addr_d       = '0;
          byte_idx_d   = '0;
          word_d       = '0;
          pend_data_d  = '0;
          pend_vld_d   = 1'b0;
          error_d      = 1'b0;
          inst_count_d = '0;
          busy_d       = 1'b1;
          state_d      = S_WAIT_BYTE;
        end
      end

      S_WAIT_BYTE: begin
        // An older buffered byte goes first; a simultaneous new strobe
        // simply refills the buffer it just vacated.
        if (pend_vld_q) begin
          wr_data_d  = pend_data_q;
          wr_addr_d  = addr_q[ADDR_SIZE-1:0];
          wr_en_d    = 1'b1;
          state_d    = S_WRITE;
          pend_vld_d = 1'b0;
          if (i_rx_done) begin
            pend_data_d = i_rx_data;
            pend_vld_d  = 1'b1;
          end
        end else if (i_rx_done) begin
          wr_data_d = i_rx_data;
          wr_addr_d = addr_q[ADDR_SIZE-1:0];
          wr_en_d   = 1'b1;
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        addr_d     = addr_q + ADDR_ONE;
        byte_idx_d = byte_idx_q + 2'd1;
        word_d     = {word_q[INST_SIZE-MEM_SIZE-1:0], wr_data_q};
        state_d    = (byte_idx_q == 2'd3) ? S_CHECK : S_WAIT_BYTE;
        if (i_rx_done) begin
          if (pend_vld_q) begin
            error_d = 1'b1;
          end else begin
            pend_data_d = i_rx_data;
            pend_vld_d  = 1'b1;
          end
        end
      end

      S_CHECK: begin
        inst_count_d = inst_count_q + CNT_ONE;
        if (word_q == HALT_W) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (addr_q == MEM_END) begin
          error_d = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_WAIT_BYTE;
        end
        if (i_rx_done) begin
          if (pend_vld_q) begin
            error_d = 1'b1;
          end else begin
            pend_data_d = i_rx_data;
            pend_vld_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        // Anything still buffered belongs to no load; drop it.
        pend_vld_d = 1'b0;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything including
  // a write strobe that is already on the port.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      pend_data_q  <= '0;
      pend_vld_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      inst_count_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      pend_data_q  <= pend_data_d;
      pend_vld_q   <= pend_vld_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      inst_count_q <= inst_count_d;
    end
  end

  assign o_mem_enable       = wr_en_q;
  assign o_mem_write_enable = wr_en_q;
  assign o_mem_write_data   = wr_data_q;
  assign o_mem_write_addr   = wr_addr_q;
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;
  assign o_inst_count       = inst_count_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: expected memory writes are queued as bytes are
// driven and matched by a monitor when the write strobe appears.
module tb_inst_mem_loader;

  logic       i_clock;
  logic       i_reset_n;
  logic       i_start;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       o_mem_enable;
  logic       o_mem_write_enable;
  logic [7:0] o_mem_write_data;
  logic [7:0] o_mem_write_addr;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic [7:0] o_inst_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_addr_q[$];
  logic [7:0] exp_data_q[$];

  inst_mem_loader dut (
    .i_clock            (i_clock),
    .i_reset_n          (i_reset_n),
    .i_start            (i_start),
    .i_rx_data          (i_rx_data),
    .i_rx_done          (i_rx_done),
    .o_mem_enable       (o_mem_enable),
    .o_mem_write_enable (o_mem_write_enable),
    .o_mem_write_data   (o_mem_write_data),
    .o_mem_write_addr   (o_mem_write_addr),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_error            (o_error),
    .o_inst_count       (o_inst_count)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge i_clock) begin
    if (i_reset_n && o_mem_write_enable) begin
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0h data=%0h, none expected", o_mem_write_addr, o_mem_write_data);
      end else begin
        logic [7:0] ea, ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (o_mem_write_addr !== ea || o_mem_write_data !== ed || o_mem_enable !== 1'b1) begin
          n_fail++;
          $display("FAIL write_match: got addr=%0h data=%0h en=%b, want addr=%0h data=%0h en=1",
                   o_mem_write_addr, o_mem_write_data, o_mem_enable, ea, ed);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_write(input logic [7:0] a, input logic [7:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clock); #1;
    i_rx_done = 1'b0;
    repeat (gap - 1) begin @(posedge i_clock); #1; end
  endtask

  task automatic start_load();
    i_start = 1'b1;
    @(posedge i_clock); #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_busy: o_busy=%b, want 1", o_busy);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge i_clock);
      if (o_done === 1'b1) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: o_done never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic check_end(input string name, input logic err, input logic [7:0] cnt);
    n_checks++;
    if (o_error !== err || o_inst_count !== cnt || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_status: error=%b count=%0d busy=%b, want error=%b count=%0d busy=0",
               name, o_error, o_inst_count, o_busy, err, cnt);
    end
    @(posedge i_clock); #1;
    repeat (4) begin @(posedge i_clock); #1; end
    n_checks++;
    if (exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_writes: %0d outstanding, want 0", name, exp_addr_q.size());
      exp_addr_q.delete();
      exp_data_q.delete();
    end
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = '0;
    repeat (3) @(posedge i_clock);
    #1;
    n_checks++;
    if ({o_mem_enable, o_mem_write_enable, o_mem_write_data, o_mem_write_addr,
         o_busy, o_done, o_error, o_inst_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero (busy=%b done=%b err=%b cnt=%0d we=%b)",
               o_busy, o_done, o_error, o_inst_count, o_mem_write_enable);
    end
    i_reset_n = 1'b1;
    @(posedge i_clock); #1;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [8];
    bytes = '{8'h20, 8'h01, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    start_load();
    for (int i = 0; i < 8; i++) begin
      push_write(8'(i), bytes[i]);
      send_byte(bytes[i], (i == 7) ? 1 : 10);
    end
    // Last strobe in cycle t: done must appear exactly in cycle t+3.
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clock);
      n_checks++;
      if (o_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_done_early: o_done=%b at cycle +%0d, want 0", o_done, k + 1);
      end
    end
    @(negedge i_clock);
    n_checks++;
    if (o_done !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_latency: o_done=%b at cycle +3, want 1", o_done);
    end
    check_end("basic", 1'b0, 8'd2);
  endtask

  task automatic test_fill();
    start_load();
    for (int i = 0; i < 256; i++) begin
      push_write(8'(i), 8'h00);
      send_byte(8'h00, 3);
    end
    wait_done("fill", 20);
    check_end("fill", 1'b1, 8'd64);
  endtask

  task automatic test_throughput();
    // Strobes every 2 cycles inside one word: nothing lost.
    start_load();
    for (int i = 0; i < 4; i++) begin
      push_write(8'(i), 8'hFF);
      send_byte(8'hFF, 2);
    end
    wait_done("tput2", 20);
    check_end("tput2", 1'b0, 8'd1);

    // Three strobes on consecutive cycles at a word boundary: the third is
    // dropped and flagged, the second is buffered and written later.
    start_load();
    push_write(8'd0, 8'hA0); send_byte(8'hA0, 3);
    push_write(8'd1, 8'hA1); send_byte(8'hA1, 3);
    push_write(8'd2, 8'hA2); send_byte(8'hA2, 3);
    push_write(8'd3, 8'hA3); send_byte(8'hA3, 1);
    push_write(8'd4, 8'hFF); send_byte(8'hFF, 1);
    send_byte(8'h55, 4);
    n_checks++;
    if (o_error !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_error: o_error=%b, want 1", o_error);
    end
    for (int i = 5; i < 8; i++) begin
      push_write(8'(i), 8'hFF);
      send_byte(8'hFF, 3);
    end
    wait_done("overrun", 20);
    check_end("overrun", 1'b1, 8'd2);
  endtask

  task automatic test_reset_mid();
    start_load();
    push_write(8'd0, 8'h11); send_byte(8'h11, 3);
    push_write(8'd1, 8'h22); send_byte(8'h22, 3);
    push_write(8'd2, 8'h33); send_byte(8'h33, 3);
    send_byte(8'h44, 1);
    #1;
    n_checks++;
    if (o_mem_write_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_inflight: write_enable=%b before reset, want 1", o_mem_write_enable);
    end
    i_reset_n = 1'b0;
    #1;
    n_checks++;
    if ({o_mem_enable, o_mem_write_enable, o_mem_write_data, o_mem_write_addr,
         o_busy, o_done, o_error, o_inst_count} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b we=%b data=%0h addr=%0h, want all 0",
               o_busy, o_mem_write_enable, o_mem_write_data, o_mem_write_addr);
    end
    @(posedge i_clock); #1;
    i_reset_n = 1'b1;
    @(posedge i_clock); #1;
    start_load();
    for (int i = 0; i < 4; i++) begin
      push_write(8'(i), 8'hFF);
      send_byte(8'hFF, 3);
    end
    wait_done("midreset", 20);
    check_end("midreset", 1'b0, 8'd1);
  endtask

  task automatic test_start_busy();
    logic [7:0] bytes [8];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    // Strobes while idle must not write or disturb the previous count.
    send_byte(8'h77, 3);
    send_byte(8'h78, 3);
    n_checks++;
    if (o_inst_count !== 8'd1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_rx: count=%0d busy=%b, want count=1 busy=0", o_inst_count, o_busy);
    end
    start_load();
    for (int i = 0; i < 8; i++) begin
      push_write(8'(i), bytes[i]);
      send_byte(bytes[i], 2);
      if (i < 7) begin
        i_start = 1'b1;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_hold: o_busy=%b after byte %0d, want 1", o_busy, i);
        end
      end
    end
    wait_done("startbusy", 20);
    check_end("startbusy", 1'b0, 8'd2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_throughput();
    test_reset_mid();
    test_start_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
